// File: rtl/id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl
//   Hazard and stall controller for the IF/ID pipeline register. It compares
//   the decoded ID-stage operands against the EX-stage destination and flag
//   update. On a hazard it holds PC and IF/ID and puts a bubble into ID/EX.
//   A taken branch resolved in ID flushes IF/ID, but only in a cycle that is
//   not stalled. Two saturating performance counters record stalled cycles
//   and flushes.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   Rn_id            ID source register 1
//   src2_id          ID source register 2 (already Reg2Loc-selected)
//   uses_src2_id     ID instruction reads src2_id
//   Rd_id            ID Rd, the operand that CBZ tests
//   cbz_id           ID instruction is CBZ
//   cond_id          ID instruction is B.cond
//   branch_taken_id  branch resolved taken in ID this cycle
//   Rd_ex            EX destination register
//   RegWrite_ex      EX instruction writes Rd_ex
//   MemtoReg_ex      EX instruction is a load
//   update_ex        EX instruction sets flags
//   pc_we            PC write enable
//   if_id_we         IF/ID write enable
//   if_id_flush      IF/ID loads a NOP on the next edge
//   id_ex_bubble     ID/EX loads zeroed control on the next edge
//   stall_count      number of stalled cycles, saturating
//   flush_count      number of flushes, saturating
// ---------------------------------------------------------------------------
module id_hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int XZR   = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rn_id,
  input  logic [4:0]       src2_id,
  input  logic             uses_src2_id,
  input  logic [4:0]       Rd_id,
  input  logic             cbz_id,
  input  logic             cond_id,
  input  logic             branch_taken_id,
  input  logic [4:0]       Rd_ex,
  input  logic             RegWrite_ex,
  input  logic             MemtoReg_ex,
  input  logic             update_ex,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [4:0] XZR_IDX = 5'(XZR);

  typedef enum logic {RUN, STALL} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, flush_count_q;

  logic       ex_writes;
  logic       match_rn, match_src2, match_rd;
  logic [1:0] need;
  logic       stall;
  logic       flush;

  // XZR is hard-wired zero, so writing it never creates a dependency.
  assign ex_writes  = RegWrite_ex && (Rd_ex != XZR_IDX);
  assign match_rn   = ex_writes && (Rd_ex == Rn_id);
  assign match_src2 = ex_writes && (Rd_ex == src2_id);
  assign match_rd   = ex_writes && (Rd_ex == Rd_id);

  // CBZ resolves in ID, so a load feeding it needs two bubbles: one to let
  // the load reach MEM and one more for its data to be forwardable to ID.
  // NOTE: every signal driven in always_comb is given a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    need = 2'd0;
    if (cbz_id && MemtoReg_ex && match_rd) begin
      need = 2'd2;
    end else if ((MemtoReg_ex && match_rn) ||
                 (MemtoReg_ex && uses_src2_id && match_src2) ||
                 (cbz_id && !MemtoReg_ex && match_rd) ||
                 (cond_id && update_ex)) begin
      need = 2'd1;
    end
  end

  assign stall = ((state_q == RUN) && (need != 2'd0)) || (state_q == STALL);
  // A branch evaluated on stale operands in a stalled cycle is ignored. It
  // is re-evaluated on the first cycle that is not stalled.
  assign flush = branch_taken_id && !stall;

  // STALL ignores the hazard inputs. The bubble already sitting in EX is
  // what would otherwise clear the match.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (need == 2'd2) begin
          state_d = STALL;
          cnt_d   = 2'd1;
        end
      end
      STALL: begin
        if (cnt_q == 2'd1) begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments, so every register
  // samples values from before the edge, whatever the order of statements.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      cnt_q         <= 2'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
      if (flush && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 1'b1;
      end
    end
  end

  // While reset is low, the outputs hold the pipeline frozen with a bubble
  // in ID/EX.
  assign pc_we        = reset && !stall;
  assign if_id_we     = reset && !stall;
  assign id_ex_bubble = !reset || stall;
  assign if_id_flush  = reset && flush;
  assign stall_count  = stall_count_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       Rn_id, src2_id, Rd_id, Rd_ex;
  logic             uses_src2_id, cbz_id, cond_id, branch_taken_id;
  logic             RegWrite_ex, MemtoReg_ex, update_ex;
  logic             pc_we, if_id_we, if_id_flush, id_ex_bubble;
  logic [CNT_W-1:0] stall_count, flush_count;

  int errors = 0;
  int checks = 0;

  id_hazard_ctrl #(.CNT_W(CNT_W), .XZR(31)) dut (
    .clk             (clk),
    .reset           (reset),
    .Rn_id           (Rn_id),
    .src2_id         (src2_id),
    .uses_src2_id    (uses_src2_id),
    .Rd_id           (Rd_id),
    .cbz_id          (cbz_id),
    .cond_id         (cond_id),
    .branch_taken_id (branch_taken_id),
    .Rd_ex           (Rd_ex),
    .RegWrite_ex     (RegWrite_ex),
    .MemtoReg_ex     (MemtoReg_ex),
    .update_ex       (update_ex),
    .pc_we           (pc_we),
    .if_id_we        (if_id_we),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Checks the four pipeline controls together: {pc_we, if_id_we, bubble, flush}.
  task automatic check_ctl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, pc_we, if_id_we, id_ex_bubble, if_id_flush}, {28'd0, exp});
  endtask

  task automatic idle();
    Rn_id = 5'd1; src2_id = 5'd2; uses_src2_id = 1'b0; Rd_id = 5'd4;
    cbz_id = 1'b0; cond_id = 1'b0; branch_taken_id = 1'b0;
    Rd_ex = 5'd0; RegWrite_ex = 1'b0; MemtoReg_ex = 1'b0; update_ex = 1'b0;
  endtask

  // Move to the next falling edge. Inputs change there, and the design is
  // sampled 1 time unit later, well away from the rising edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  localparam logic [3:0] RUN_CTL   = 4'b1100;
  localparam logic [3:0] STALL_CTL = 4'b0010;
  localparam logic [3:0] FLUSH_CTL = 4'b1101;

  initial begin
    idle();
    reset = 1'b0;
    #2;
    check_ctl("reset_ctl", STALL_CTL);
    check("reset_stall_cnt", 32'(stall_count), 0);
    check("reset_flush_cnt", 32'(flush_count), 0);

    next_cycle(); reset = 1'b1; settle();
    check_ctl("idle_run", RUN_CTL);

    // Load-use on Rn: exactly one stall cycle.
    next_cycle(); MemtoReg_ex = 1; RegWrite_ex = 1; Rd_ex = 5'd5; Rn_id = 5'd5; settle();
    check_ctl("lu_rn_stall", STALL_CTL);
    next_cycle(); idle(); Rn_id = 5'd5; settle();
    check_ctl("lu_rn_release", RUN_CTL);
    check("lu_rn_cnt", 32'(stall_count), 1);

    // Load then CBZ: two stalls. The second cycle has an EX bubble and must
    // still stall.
    next_cycle(); MemtoReg_ex = 1; RegWrite_ex = 1; Rd_ex = 5'd3; cbz_id = 1; Rd_id = 5'd3; settle();
    check_ctl("ldcbz_stall1", STALL_CTL);
    next_cycle(); idle(); cbz_id = 1; Rd_id = 5'd3; settle();
    check_ctl("ldcbz_stall2", STALL_CTL);
    next_cycle(); settle();
    check_ctl("ldcbz_release", RUN_CTL);
    check("ldcbz_cnt", 32'(stall_count), 3);

    // Flag hazard, first without and then with a taken branch.
    next_cycle(); idle(); cond_id = 1; update_ex = 1; settle();
    check_ctl("flag_stall", STALL_CTL);
    next_cycle(); update_ex = 0; settle();
    check_ctl("flag_release", RUN_CTL);
    check("flag_cnt", 32'(stall_count), 4);
    next_cycle(); update_ex = 1; branch_taken_id = 1; settle();
    check_ctl("br_stall_noflush", STALL_CTL);
    next_cycle(); update_ex = 0; settle();
    check_ctl("br_flush", FLUSH_CTL);
    next_cycle(); idle(); settle();
    check("br_flush_cnt", 32'(flush_count), 1);
    check("br_stall_cnt", 32'(stall_count), 5);

    // XZR never stalls, even for a load.
    next_cycle(); MemtoReg_ex = 1; RegWrite_ex = 1; Rd_ex = 5'd31; Rn_id = 5'd31; settle();
    check_ctl("xzr_load", RUN_CTL);
    // A src2 match with uses_src2_id=0 is not a hazard; with uses_src2_id=1 it is.
    next_cycle(); idle(); MemtoReg_ex = 1; RegWrite_ex = 1; Rd_ex = 5'd7; src2_id = 5'd7; settle();
    check_ctl("src2_unused", RUN_CTL);
    uses_src2_id = 1; settle();
    check_ctl("src2_used", STALL_CTL);
    // CBZ after an ALU write: one stall.
    next_cycle(); idle(); RegWrite_ex = 1; Rd_ex = 5'd9; cbz_id = 1; Rd_id = 5'd9; settle();
    check_ctl("cbz_alu", STALL_CTL);
    // A load with RegWrite_ex=0 is not a dependency.
    next_cycle(); idle(); MemtoReg_ex = 1; Rd_ex = 5'd5; Rn_id = 5'd5; settle();
    check_ctl("no_regwrite", RUN_CTL);
    check("misc_cnt", 32'(stall_count), 7);

    // Reset in the middle of a two-cycle stall.
    next_cycle(); idle(); MemtoReg_ex = 1; RegWrite_ex = 1; Rd_ex = 5'd3; cbz_id = 1; Rd_id = 5'd3; settle();
    check_ctl("rst_pre_stall", STALL_CTL);
    next_cycle(); idle(); reset = 1'b0; settle();
    check_ctl("rst_mid_ctl", STALL_CTL);
    check("rst_mid_stall_cnt", 32'(stall_count), 0);
    check("rst_mid_flush_cnt", 32'(flush_count), 0);
    next_cycle(); reset = 1'b1; settle();
    check_ctl("rst_release_run", RUN_CTL);
    check("rst_release_cnt", 32'(stall_count), 0);

    // Saturation at 2^CNT_W-1 = 15 after 20 stalled cycles.
    next_cycle(); cond_id = 1; update_ex = 1;
    for (int i = 0; i < 20; i++) next_cycle();
    settle();
    check("sat_cnt", 32'(stall_count), 15);
    next_cycle(); idle(); settle();
    check("sat_hold", 32'(stall_count), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
